rr_onehot_arbiter: RTL

- Round-robin arbiter placed directly upstream of the 8-to-3 encoder.
- Takes up to N request lines and produces a registered grant vector that is either all-zero or strictly one-hot, so the encoder is never driven with an undefined input.
- Each grant is held while its requester keeps its request asserted; priority then rotates.
- A compile-time option adds a maximum-hold timeout.

---
 rtl/rr_onehot_arbiter_if.sv | 23 ++
 rtl/rr_onehot_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface rr_onehot_arbiter_if #(
  parameter int N = 8
);
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic         gnt_valid_o;
  logic         timeout_o;

  modport master (
    output req_i,
    input  gnt_o,
    input  gnt_valid_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    output gnt_o,
    output gnt_valid_o,
    output timeout_o
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered all-zero/one-hot grant, 1-cycle request-to-grant latency;
// no backpressure (grant held while requested). ARB_TIMEOUT_EN adds a MAX_HOLD forced release.
module rr_onehot_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  rr_onehot_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] GNT_ONE = N'(1);

  if (N < 2) begin : g_bad_n
    $error("rr_onehot_arbiter: N must be at least 2");
  end
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("rr_onehot_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] idx_next;
  logic          owner_dropped;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // Wrap-around search starting at ptr: the first set request wins.
  always_comb begin
    int            k;
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    k         = 0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      k    = (int'(ptr_q) + i) % N;
      cand = PW'(k);
      if (!win_found && bus.req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign idx_next      = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;
  assign owner_dropped = ~bus.req_i[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          gnt_d   = GNT_ONE << win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
        // A normal drop takes precedence over a timeout landing on the same edge.
        if (owner_dropped) begin
          state_d = IDLE;
          ptr_d   = idx_next;
          gnt_d   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          ptr_d     = idx_next;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_valid_o = gnt_valid_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) $onehot0(gnt_q));
  a_gnt_matches_state : assert property (
    @(posedge clk_i) disable iff (!rst_ni) ((state_q == GRANT) == (gnt_q != '0)));

endmodule
